mv_bram_engine: RTL and testbench

// - Parametrised matrix-vector engine: y = sat((M * x) >>> OUT_SHIFT), driven by start, results written back to BRAM.
// - Loads vector x (VEC_LEN words) into local regs, streams ROWS matrix rows over one shared BRAM port and MACs each row.
// - Successor of the fixed 8-bit PE-array controller: adds width/depth/latency params, signed/unsigned mode, saturating write-back.

---
 rtl/mv_bram_engine_pkg.sv | 41 ++++
 rtl/mv_bram_engine_if.sv | 15 +
 rtl/mv_bram_engine_mac_sat.sv | 43 ++++
 rtl/mv_bram_engine.sv | 210 +++++++++++++++++++++
 tb/tb_mv_bram_engine.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mv_bram_engine_pkg.sv
// Shared types and helpers for the matrix-vector BRAM engine.
package mv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_VEC,
    ST_VEC_DRAIN,
    ST_ROW_RD,
    ST_ROW_DRAIN,
    ST_WRITE,
    ST_FIN
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WE_ALL     = 4'hF;

  function automatic int unsigned acc_w_f(input int unsigned data_w, input int unsigned vec_len);
    return 2 * data_w + $clog2(vec_len);
  endfunction

  localparam int unsigned ACC_W = acc_w_f(8, 8);

  // Clamp a sign-extended accumulator into the signed or unsigned DATA_W range.
  function automatic logic signed [63:0] sat_f(input logic signed [63:0] acc,
                                               input logic               signed_mode,
                                               input int unsigned        data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (signed_mode) begin
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
    end else begin
      hi = (64'sd1 <<< data_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/mv_bram_engine_if.sv
// Single shared BRAM port between the engine (master) and the memory (slave).
interface mv_bram_engine_if #(
  parameter int unsigned DATA_W = 8
);
  logic [31:0]       BRAM_ADDR;
  logic [DATA_W-1:0] BRAM_WRDATA;
  logic [3:0]        BRAM_WE;
  logic              BRAM_CLK;
  logic [DATA_W-1:0] BRAM_RDDATA;

  modport master (output BRAM_ADDR, output BRAM_WRDATA, output BRAM_WE, output BRAM_CLK,
                  input  BRAM_RDDATA);
  modport slave  (input  BRAM_ADDR, input  BRAM_WRDATA, input  BRAM_WE, input  BRAM_CLK,
                  output BRAM_RDDATA);
endinterface

// File: rtl/mv_bram_engine_mac_sat.sv
// Row accumulator: multiply-accumulate, then arithmetic shift and saturate.
module mv_mac_sat
  import mv_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned VEC_LEN   = 8,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sat_c_o
);

  localparam int unsigned AW  = acc_w_f(DATA_W, VEC_LEN);
  localparam logic        SGN = (SIGNED != 0);

  logic [AW-1:0]      acc_q, acc_d;
  logic [AW-1:0]      a_w, b_w, prod;
  logic signed [63:0] acc_ext;

  // Product modulo 2^AW is exact for both signednesses once operands are extended.
  always_comb begin
    a_w   = {{(AW-DATA_W){SGN & a_i[DATA_W-1]}}, a_i};
    b_w   = {{(AW-DATA_W){SGN & b_i[DATA_W-1]}}, b_i};
    prod  = a_w * b_w;
    acc_d = acc_q;
    if (en_i) acc_d = (clr_i ? AW'(0) : acc_q) + prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_ext = {{(64-AW){SGN & acc_q[AW-1]}}, acc_q};
  assign sat_c_o = DATA_W'(sat_f(acc_ext >>> OUT_SHIFT, SGN, DATA_W));

endmodule

// File: rtl/mv_bram_engine.sv
// Matrix-vector engine: y = sat((M * x) >>> OUT_SHIFT) over one shared BRAM port.
module mv_bram_engine
  import mv_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned VEC_LEN   = 8,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned OUT_SHIFT = 0,
  parameter int unsigned VEC_BASE  = 0,
  parameter int unsigned MAT_BASE  = 4 * VEC_LEN,
  parameter int unsigned RES_BASE  = 4 * VEC_LEN * (ROWS + 1)
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start,
  output logic              done,
  output logic              busy,
  mv_bram_engine_if.master  bram
);

  localparam int unsigned KW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int unsigned RW = (ROWS > 1)    ? $clog2(ROWS)    : 1;
  localparam int unsigned DW = (RD_LAT > 1)  ? $clog2(RD_LAT)  : 1;

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [RW-1:0]     r_q, r_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              issue_c, issue_vec_c;
  logic              k_last_c, r_last_c, dly_last_c;
  logic [31:0]       vec_addr_c, mat_addr_c, res_addr_c;
  logic [DATA_W-1:0] sat_c;

  logic [RD_LAT-1:0]         tvld_q, tvec_q;
  logic [RD_LAT-1:0][KW-1:0] tidx_q;
  logic [VEC_LEN-1:0][DATA_W-1:0] x_q;

  logic              ret_vld_c, ret_vec_c;
  logic [KW-1:0]     ret_idx_c;

  assign k_last_c   = (k_q == KW'(VEC_LEN - 1));
  assign r_last_c   = (r_q == RW'(ROWS - 1));
  assign dly_last_c = (dly_q == DW'(RD_LAT - 1));

  assign vec_addr_c = 32'(VEC_BASE) + 32'(WORD_BYTES) * 32'(k_q);
  assign mat_addr_c = 32'(MAT_BASE) + 32'(WORD_BYTES) * (32'(r_q) * 32'(VEC_LEN) + 32'(k_q));
  assign res_addr_c = 32'(RES_BASE) + 32'(WORD_BYTES) * 32'(r_q);

  // Next-state, counters and registered BRAM/status outputs.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    dly_d       = dly_q;
    addr_d      = addr_q;
    we_d        = '0;
    wr_d        = wr_q;
    done_d      = 1'b0;
    issue_c     = 1'b0;
    issue_vec_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_VEC;
          k_d     = '0;
          r_d     = '0;
        end
      end
      ST_LOAD_VEC: begin
        issue_c     = 1'b1;
        issue_vec_c = 1'b1;
        addr_d      = vec_addr_c;
        if (k_last_c) begin
          k_d     = '0;
          dly_d   = '0;
          state_d = ST_VEC_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_VEC_DRAIN: begin
        if (dly_last_c) begin
          dly_d   = '0;
          state_d = ST_ROW_RD;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      ST_ROW_RD: begin
        issue_c = 1'b1;
        addr_d  = mat_addr_c;
        if (k_last_c) begin
          k_d     = '0;
          dly_d   = '0;
          state_d = ST_ROW_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_ROW_DRAIN: begin
        if (dly_last_c) begin
          dly_d   = '0;
          state_d = ST_WRITE;
        end else begin
          dly_d = dly_q + DW'(1);
        end
      end
      ST_WRITE: begin
        addr_d = res_addr_c;
        we_d   = WE_ALL;
        wr_d   = sat_c;
        if (r_last_c) begin
          r_d     = '0;
          state_d = ST_FIN;
        end else begin
          r_d     = r_q + RW'(1);
          state_d = ST_ROW_RD;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      r_q     <= '0;
      dly_q   <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      dly_q   <= dly_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Tags travel alongside the read so each return knows its target and index.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tvld_q <= '0;
      tvec_q <= '0;
      tidx_q <= '0;
    end else begin
      tvld_q[0] <= issue_c;
      tvec_q[0] <= issue_vec_c;
      tidx_q[0] <= k_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tvld_q[i] <= tvld_q[i-1];
        tvec_q[i] <= tvec_q[i-1];
        tidx_q[i] <= tidx_q[i-1];
      end
    end
  end

  assign ret_vld_c = tvld_q[RD_LAT-1];
  assign ret_vec_c = tvec_q[RD_LAT-1];
  assign ret_idx_c = tidx_q[RD_LAT-1];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)               x_q            <= '0;
    else if (ret_vld_c && ret_vec_c)  x_q[ret_idx_c] <= bram.BRAM_RDDATA;
  end

  mv_mac_sat #(
    .DATA_W    (DATA_W),
    .VEC_LEN   (VEC_LEN),
    .SIGNED    (SIGNED),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .en_i    (ret_vld_c & ~ret_vec_c),
    .clr_i   (ret_idx_c == '0),
    .a_i     (bram.BRAM_RDDATA),
    .b_i     (x_q[ret_idx_c]),
    .sat_c_o (sat_c)
  );

  assign done             = done_q;
  assign busy             = busy_q;
  assign bram.BRAM_ADDR   = addr_q;
  assign bram.BRAM_WE     = we_q;
  assign bram.BRAM_WRDATA = wr_q;
  assign bram.BRAM_CLK    = ~S_AXI_ACLK;

endmodule

// File: tb/tb_mv_bram_engine.sv
// Scoreboard bench: two engine configurations against an arithmetic reference model.
module tb_mv_bram_engine;

  localparam int A_VL = 8, A_R = 8, A_LAT = 2, A_SG = 1, A_SH = 0;
  localparam int B_VL = 4, B_R = 3, B_LAT = 1, B_SG = 0, B_SH = 2;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic done_a, busy_a, done_b, busy_b;

  mv_bram_engine_if #(.DATA_W(8)) if_a ();
  mv_bram_engine_if #(.DATA_W(8)) if_b ();

  mv_bram_engine #(.DATA_W(8), .VEC_LEN(A_VL), .ROWS(A_R), .RD_LAT(A_LAT),
                   .SIGNED(A_SG), .OUT_SHIFT(A_SH)) dut_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_a),
    .done(done_a), .busy(busy_a), .bram(if_a));

  mv_bram_engine #(.DATA_W(8), .VEC_LEN(B_VL), .ROWS(B_R), .RD_LAT(B_LAT),
                   .SIGNED(B_SG), .OUT_SHIFT(B_SH)) dut_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_b),
    .done(done_b), .busy(busy_b), .bram(if_b));

  always #5 clk = ~clk;

  logic [7:0]  mem_a [128];
  logic [7:0]  mem_b [64];
  logic [31:0] a1_a;
  wr_t exp_a[$];
  wr_t exp_b[$];
  int n_cmp = 0, n_fail = 0;
  int done_cnt_a = 0, done_cnt_b = 0, we_cnt_a = 0, we_cnt_b = 0;

  // BRAM models clocked on BRAM_CLK: two-stage read for A, single-stage for B.
  always @(posedge if_a.BRAM_CLK) begin
    a1_a <= if_a.BRAM_ADDR;
    if_a.BRAM_RDDATA <= mem_a[a1_a[8:2]];
  end
  always @(posedge if_b.BRAM_CLK) if_b.BRAM_RDDATA <= mem_b[if_b.BRAM_ADDR[7:2]];

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic mon_wr(input int w, input logic [31:0] addr, input logic [3:0] we,
                        input logic [7:0] data);
    wr_t e;
    bit  empty;
    cmp("we_mask", longint'(we), 15);
    empty = (w == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
    if (empty) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_write dut%0d: addr %0d data %0d, no write required", w, addr, data);
    end else begin
      if (w == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      cmp(w == 0 ? "wr_addr_a" : "wr_addr_b", longint'(addr), longint'(e.addr));
      cmp(w == 0 ? "wr_data_a" : "wr_data_b", longint'(data), longint'(e.data));
    end
  endtask

  // Monitor: pops the scoreboard whenever a write strobe is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
      if (if_a.BRAM_WE != 4'h0) begin
        we_cnt_a++;
        mon_wr(0, if_a.BRAM_ADDR, if_a.BRAM_WE, if_a.BRAM_WRDATA);
      end
      if (if_b.BRAM_WE != 4'h0) begin
        we_cnt_b++;
        mon_wr(1, if_b.BRAM_ADDR, if_b.BRAM_WE, if_b.BRAM_WRDATA);
      end
    end
  end

  function automatic longint elem(input int w, input int idx);
    logic [7:0] v;
    bit sg;
    v  = (w == 0) ? mem_a[idx] : mem_b[idx];
    sg = (w == 0) ? (A_SG != 0) : (B_SG != 0);
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction

  // y[r] = clamp(floor(sum_k M[r][k]*x[k] / 2^shift)) in plain integer arithmetic.
  function automatic int ref_y(input int w, input int r);
    longint acc, hi, lo;
    int vl, sh;
    bit sg;
    vl  = (w == 0) ? A_VL : B_VL;
    sh  = (w == 0) ? A_SH : B_SH;
    sg  = (w == 0) ? (A_SG != 0) : (B_SG != 0);
    acc = 0;
    for (int k = 0; k < vl; k++) acc += elem(w, k) * elem(w, vl + r * vl + k);
    acc = acc >>> sh;
    hi  = sg ? 127 : 255;
    lo  = sg ? -128 : 0;
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return int'(acc & 255);
  endfunction

  task automatic set_mem(input int w, input int idx, input logic [7:0] v);
    if (w == 0) mem_a[idx] = v;
    else        mem_b[idx] = v;
  endtask

  // Modes: 0 identity/x=1..n, 1 all 7F, 2 all FF, 3 x=-1 with rows 1..n and 80s,
  // 4 random, 5 all ones, 6 small random.
  task automatic fill(input int w, input int mode);
    int vl, rows, r, k;
    logic [7:0] v;
    vl   = (w == 0) ? A_VL : B_VL;
    rows = (w == 0) ? A_R : B_R;
    for (int i = 0; i < vl * (rows + 1); i++) begin
      r = (i - vl) / vl;
      k = (i < vl) ? i : (i - vl) % vl;
      v = 8'($urandom_range(255, 0));
      case (mode)
        0: v = (i < vl) ? 8'(k + 1) : ((r == k) ? 8'd1 : 8'd0);
        1: v = 8'h7F;
        2: v = 8'hFF;
        3: if (i < vl) v = 8'hFF; else if (r == 0) v = 8'(k + 1); else if (r == 1) v = 8'h80;
        5: v = 8'h01;
        6: v = 8'($urandom_range(31, 0));
        default: ;
      endcase
      set_mem(w, i, v);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v;
    else        start_b = v;
  endtask

  task automatic run(input int w, input int mode, input bit extra, input int rst_at);
    int vl, rows, lat, cyc, d0, w0, qn;
    bit got;
    vl   = (w == 0) ? A_VL : B_VL;
    rows = (w == 0) ? A_R : B_R;
    lat  = vl + ((w == 0) ? A_LAT : B_LAT);
    lat  = lat + rows * (lat + 1) + 1;
    fill(w, mode);
    for (int r = 0; r < rows; r++) begin
      if (w == 0) exp_a.push_back('{addr: 4 * vl * (rows + 1) + 4 * r, data: ref_y(w, r)});
      else        exp_b.push_back('{addr: 4 * vl * (rows + 1) + 4 * r, data: ref_y(w, r)});
    end
    d0 = (w == 0) ? done_cnt_a : done_cnt_b;
    w0 = (w == 0) ? we_cnt_a : we_cnt_b;
    @(posedge clk); #1 set_start(w, 1'b1);
    @(posedge clk); #1 set_start(w, 1'b0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(posedge clk); cyc++; #1;
      if (cyc == 1) cmp("busy_running", longint'((w == 0) ? busy_a : busy_b), 1);
      if ((w == 0) ? done_a : done_b) got = 1'b1;
      else if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        cmp("rst_done", longint'(done_a), 0);
        cmp("rst_busy", longint'(busy_a), 0);
        cmp("rst_addr", longint'(if_a.BRAM_ADDR), 0);
        cmp("rst_we", longint'(if_a.BRAM_WE), 0);
        cmp("rst_wrdata", longint'(if_a.BRAM_WRDATA), 0);
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        cmp("no_done_after_abort", longint'(done_cnt_a - d0), 0);
        cmp("no_we_after_abort", longint'(we_cnt_a - w0), 2);
        return;
      end
      set_start(w, extra && (cyc == 4 || cyc == 49));
    end
    cmp(w == 0 ? "done_latency_a" : "done_latency_b", cyc, lat);
    cmp("busy_at_done", longint'((w == 0) ? busy_a : busy_b), 0);
    set_start(w, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    qn = (w == 0) ? exp_a.size() : exp_b.size();
    cmp("done_pulses", longint'(((w == 0) ? done_cnt_a : done_cnt_b) - d0), 1);
    cmp("we_pulses", longint'(((w == 0) ? we_cnt_a : we_cnt_b) - w0), rows);
    cmp("pending_writes", qn, 0);
    if (w == 0) exp_a.delete();
    else        exp_b.delete();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset_done_a", longint'(done_a), 0);
    cmp("reset_busy_a", longint'(busy_a), 0);
    cmp("reset_addr_a", longint'(if_a.BRAM_ADDR), 0);
    cmp("reset_we_a", longint'(if_a.BRAM_WE), 0);
    cmp("reset_wrdata_a", longint'(if_a.BRAM_WRDATA), 0);
    cmp("reset_done_b", longint'(done_b), 0);
    cmp("reset_busy_b", longint'(busy_b), 0);
    cmp("reset_we_b", longint'(if_b.BRAM_WE), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 0, 1'b0, -1);
    run(0, 1, 1'b0, -1);
    run(0, 2, 1'b0, -1);
    run(0, 3, 1'b0, -1);
    for (int i = 0; i < 3; i++) run(0, 4, 1'b0, -1);
    run(0, 6, 1'b0, -1);
    run(0, 0, 1'b1, -1);
    run(0, 4, 1'b0, 40);
    run(0, 4, 1'b0, -1);

    run(1, 5, 1'b0, -1);
    run(1, 2, 1'b0, -1);
    run(1, 0, 1'b0, -1);
    for (int i = 0; i < 3; i++) run(1, 6, 1'b0, -1);
    run(1, 4, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
